// File: rtl/csr_ioq_pkg.sv
// csr_ioq_pkg: field layout, packet types and status codes of the 256-bit csr_ioq / ioq_csr word.
package csr_ioq_pkg;
  localparam int TYPE_LSB = 0;
  localparam int TYPE_W   = 4;
  localparam int ADDR_LSB = 4;
  localparam int ADDR_W   = 64;
  localparam int DATA_LSB = 68;
  localparam int DATA_W   = 128;
  localparam int BE_LSB   = 196;
  localparam int BE_W     = 8;
  localparam int DW_LSB   = 204;
  localparam int DW_W     = 11;
  localparam int TAG_LSB  = 215;
  localparam int TAG_W    = 6;
  localparam int STAT_LSB = 221;
  localparam int STAT_W   = 3;

  typedef enum logic [TYPE_W-1:0] {
    MEM_RD  = 4'b0000,
    MEM_WR  = 4'b0001,
    CFG_RD0 = 4'b1000,
    CFG_RD1 = 4'b1001,
    CPL     = 4'b1010,
    CPLD    = 4'b1011
  } pkt_type_e;

  typedef enum logic [STAT_W-1:0] {
    CS_SC  = 3'd0,
    CS_UR  = 3'd1,
    CS_CRS = 3'd2,
    CS_CA  = 3'd4
  } cpl_status_e;

  function automatic logic is_np(input logic [TYPE_W-1:0] t);
    return t == MEM_RD || t == CFG_RD0 || t == CFG_RD1;
  endfunction

  function automatic logic is_cpl(input logic [TYPE_W-1:0] t);
    return t == CPL || t == CPLD;
  endfunction
endpackage

// File: rtl/csr_tag_table.sv
// csr_tag_table: per-tag valid/type/issue-stamp storage with one set, two clears and three lookups.
module csr_tag_table
  import csr_ioq_pkg::*;
#(
  parameter int NUM_TAGS = 64,
  parameter int TIMER_W  = 20
) (
  input  logic               user_clk,
  input  logic               user_reset,
  input  logic               set_en,
  input  logic [TAG_W-1:0]   set_tag,
  input  logic [3:0]         set_type,
  input  logic [TIMER_W-1:0] set_stamp,
  input  logic               clr_a_en,
  input  logic [TAG_W-1:0]   clr_a_tag,
  input  logic               clr_b_en,
  input  logic [TAG_W-1:0]   clr_b_tag,
  input  logic [TAG_W-1:0]   lk_tag,
  output logic               lk_valid,
  output logic [3:0]         lk_type,
  input  logic [TAG_W-1:0]   scan_tag,
  output logic               scan_valid,
  output logic [TIMER_W-1:0] scan_stamp,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               req_valid
);
  logic [NUM_TAGS-1:0] valid;
  logic [3:0]          typ   [NUM_TAGS];
  logic [TIMER_W-1:0]  stamp [NUM_TAGS];

  function automatic logic in_rng(input logic [TAG_W-1:0] t);
    return 32'(t) < NUM_TAGS;
  endfunction

  assign lk_valid   = in_rng(lk_tag) && valid[lk_tag];
  assign lk_type    = typ[lk_tag];
  assign scan_valid = in_rng(scan_tag) && valid[scan_tag];
  assign scan_stamp = stamp[scan_tag];
  assign req_valid  = in_rng(req_tag) && valid[req_tag];

  // set is applied after both clears so a same-cycle re-issue re-arms the entry
  always_ff @(posedge user_clk or posedge user_reset)
    if (user_reset) valid <= '0;
    else valid <= (valid & ~((NUM_TAGS'(clr_a_en) << clr_a_tag) | (NUM_TAGS'(clr_b_en) << clr_b_tag)))
                  | (NUM_TAGS'(set_en) << set_tag);

  always_ff @(posedge user_clk)
    if (set_en) begin
      typ[set_tag]   <= set_type;
      stamp[set_tag] <= set_stamp;
    end
endmodule

// File: rtl/csr_cpl_tracker.sv
// csr_cpl_tracker: tracks non-posted CSR requests by tag, matches completions, reports unexpected/dup/timeout.
// Define CSR_CPL_STATS_EN to build the saturating stat_* counters; otherwise they are tied to 0.
module csr_cpl_tracker
  import csr_ioq_pkg::*;
#(
  parameter int NUM_TAGS       = 64,
  parameter int TIMER_W        = 20,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic         user_clk,
  input  logic         user_reset,
  input  logic         user_lnk_up,
  input  logic [255:0] csr_ioq_data,
  input  logic         csr_ioq_valid,
  input  logic [255:0] ioq_csr_data,
  input  logic         ioq_csr_valid,
  output logic [127:0] cpl_data,
  output logic [5:0]   cpl_tag,
  output logic [2:0]   cpl_status,
  output logic [3:0]   cpl_req_type,
  output logic         cpl_valid,
  output logic         err_unexp,
  output logic         err_dup,
  output logic         err_timeout,
  output logic [5:0]   err_tag,
  output logic [6:0]   outstanding,
  output logic [31:0]  stat_cpl,
  output logic [31:0]  stat_unexp,
  output logic [31:0]  stat_timeout
);
  logic [TIMER_W-1:0] ts, scan_stamp, age;
  logic [TAG_W-1:0]   ptr, req_tag, rsp_tag;
  logic [3:0]         req_type, rsp_type, lk_type;
  logic lk_valid, scan_valid, req_valid;
  logic rsp_is_cpl, rsp_hit, rsp_miss, req_np, req_live, expire, dup, set_new;
  logic unused_bits;

  assign req_type    = csr_ioq_data[TYPE_LSB +: TYPE_W];
  assign req_tag     = csr_ioq_data[TAG_LSB +: TAG_W];
  assign rsp_type    = ioq_csr_data[TYPE_LSB +: TYPE_W];
  assign rsp_tag     = ioq_csr_data[TAG_LSB +: TAG_W];
  assign unused_bits = ^{csr_ioq_data, ioq_csr_data};

  csr_tag_table #(.NUM_TAGS(NUM_TAGS), .TIMER_W(TIMER_W)) u_table (
    .user_clk  (user_clk),
    .user_reset(user_reset),
    .set_en    (req_np),
    .set_tag   (req_tag),
    .set_type  (req_type),
    .set_stamp (ts),
    .clr_a_en  (rsp_hit),
    .clr_a_tag (rsp_tag),
    .clr_b_en  (expire),
    .clr_b_tag (ptr),
    .lk_tag    (rsp_tag),
    .lk_valid  (lk_valid),
    .lk_type   (lk_type),
    .scan_tag  (ptr),
    .scan_valid(scan_valid),
    .scan_stamp(scan_stamp),
    .req_tag   (req_tag),
    .req_valid (req_valid)
  );

  always_comb begin
    rsp_is_cpl = ioq_csr_valid && is_cpl(rsp_type);
    rsp_hit    = rsp_is_cpl && lk_valid;
    rsp_miss   = rsp_is_cpl && !lk_valid;
    age        = ts - scan_stamp;
    expire     = scan_valid && 32'(age) >= TIMEOUT_CYCLES && !(rsp_hit && rsp_tag == ptr);
    req_np     = csr_ioq_valid && user_lnk_up && is_np(req_type) && 32'(req_tag) < NUM_TAGS;
    req_live   = req_valid && !(rsp_hit && rsp_tag == req_tag) && !(expire && ptr == req_tag);
    dup        = req_np && req_live;
    set_new    = req_np && !req_live;
  end

  always_ff @(posedge user_clk or posedge user_reset)
    if (user_reset) begin
      ts           <= '0;
      ptr          <= '0;
      outstanding  <= '0;
      cpl_valid    <= 1'b0;
      cpl_data     <= '0;
      cpl_tag      <= '0;
      cpl_status   <= '0;
      cpl_req_type <= '0;
      err_unexp    <= 1'b0;
      err_dup      <= 1'b0;
      err_timeout  <= 1'b0;
      err_tag      <= '0;
    end else begin
      ts          <= ts + TIMER_W'(user_lnk_up);
      ptr         <= 32'(ptr) == NUM_TAGS - 1 ? '0 : ptr + TAG_W'(1);
      outstanding <= outstanding + 7'(set_new) - 7'(rsp_hit) - 7'(expire);
      cpl_valid   <= rsp_hit;
      err_unexp   <= rsp_miss;
      err_dup     <= dup;
      err_timeout <= expire;
      if (rsp_hit) begin
        cpl_data     <= ioq_csr_data[DATA_LSB +: DATA_W];
        cpl_tag      <= rsp_tag;
        cpl_status   <= ioq_csr_data[STAT_LSB +: STAT_W];
        cpl_req_type <= lk_type;
      end
      if (rsp_miss || dup || expire) err_tag <= rsp_miss ? rsp_tag : dup ? req_tag : ptr;
    end

`ifdef CSR_CPL_STATS_EN
  always_ff @(posedge user_clk or posedge user_reset)
    if (user_reset) begin
      stat_cpl     <= '0;
      stat_unexp   <= '0;
      stat_timeout <= '0;
    end else begin
      if (rsp_hit && !(&stat_cpl)) stat_cpl <= stat_cpl + 32'd1;
      if (rsp_miss && !(&stat_unexp)) stat_unexp <= stat_unexp + 32'd1;
      if (expire && !(&stat_timeout)) stat_timeout <= stat_timeout + 32'd1;
    end
`else
  assign stat_cpl     = '0;
  assign stat_unexp   = '0;
  assign stat_timeout = '0;
`endif
endmodule
